conv3x3_frame_ctrl: RTL
=======================

CONV3X3_FRAME_CTRL -- requirements
Module: conv3x3_frame_ctrl

Interface
REQ-001 Parameter IMG_W, default 256: pixels per row; SHALL be at least 3.
REQ-002 Parameter IMG_H, default 256: rows per frame; SHALL be at least 3.
REQ-003 Parameter PIX_W, default 8: stream pixel width.
REQ-004 Parameter KPIX_W, default 17: kernel port width.
REQ-005 clk  in  1  sole clock; all state SHALL change on its rising edge only.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 start  in  1  one-cycle frame start request.
REQ-008 busy  out  1  high from an accepted start until done.
REQ-009 done  out  1  one-cycle pulse after the last output transfer of a frame.
REQ-010 in_valid / in_ready / in_pix  in / out / in  1 / 1 / PIX_W  raster-order input stream.
REQ-011 out_valid / out_ready / out_pix  out / in / out  1 / 1 / PIX_W  filtered output stream.
REQ-012 k_p0..k_p8  out  KPIX_W each  3x3 window driven to the combinational kernel; p0 is top-left and p8 is bottom-right, in row-major order; each is zero-extended from PIX_W.
REQ-013 k_result  in  KPIX_W  kernel output, already clipped to the range 0..255.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DRAIN.
REQ-015 IDLE->RUN on start; start in RUN or DRAIN SHALL be ignored.
REQ-016 RUN->DRAIN on acceptance of input pixel (IMG_H-1, IMG_W-1).
REQ-017 DRAIN->IDLE on the out_valid and out_ready transfer of the final output; done SHALL pulse in the same edge's next cycle.
REQ-018 in_ready = (state==RUN) and (!out_valid or out_ready); an input is accepted when in_valid and in_ready are both high.
REQ-019 Column counter 0..IMG_W-1 and row counter 0..IMG_H-1 SHALL advance on each accept; column wraps to 0 and increments row; both SHALL clear on start.
REQ-020 Two IMG_W-deep line buffers SHALL hold rows r-1 and r-2; on each accept, in_pix is written at column c and the old entry shifts down one buffer.
REQ-021 A 3x3 window shift register SHALL shift left by one column on each accept, loading {line2[c], line1[c], in_pix} as the new right column.
REQ-022 k_p0..k_p8 SHALL present the post-shift window combinationally, formed from the current registers plus the new column.
REQ-023 An accept at (r,c) with r>=2 and c>=2 SHALL emit output for center (r-1,c-1): out_pix <= k_result[PIX_W-1:0] and out_valid <= 1 on that edge, giving a latency of 1 cycle.
REQ-024 Accepts with r<2 or c<2 SHALL produce no output; a frame SHALL yield exactly (IMG_H-2)*(IMG_W-2) outputs, with no border outputs.
REQ-025 out_valid SHALL hold, with out_pix stable, until out_ready; a transfer and a new accept in the same cycle SHALL replace the value with no gap.
REQ-026 Window columns SHALL NOT span a row wrap, because outputs are gated by c>=2.
REQ-027 Back-to-back frames: start on the cycle done is high SHALL be accepted.

Reset
REQ-028 On rst: state=IDLE, busy=0, done=0, out_valid=0, out_pix=0, in_ready=0, and counters and window registers =0.
REQ-029 Line-buffer contents need not be cleared.
REQ-030 rst mid-frame SHALL abort the frame with no done pulse, and any pending output SHALL be dropped.

Structure
REQ-031 Package conv_pkg SHALL hold the state enum and the default IMG_W, IMG_H, PIX_W and KPIX_W constants.
REQ-032 Sub-module line_buffer SHALL be a parameterised single-clock RAM, IMG_W x PIX_W, with read-before-write at the same address; it SHALL be instantiated twice.
REQ-033 The kernel SHALL be instantiated outside this block and connected through k_p* and k_result.

Verification
REQ-034 IMG_W=IMG_H=4, constant 100, emboss kernel, out_ready=1 -> 4 outputs of 100, then done, with busy high throughout.
REQ-035 IMG_W=IMG_H=4, raster ramp 0..15, identity kernel (result=p4) -> outputs 5, 6, 9, 10 in order.
REQ-036 Same as REQ-035 with out_ready toggling 1-0-0-1 -> in_ready low while output is held, with no loss or duplication.
REQ-037 Pulse start again mid-frame -> ignored, and the counts and outputs are unchanged.
REQ-038 Assert rst after 7 accepts -> next cycle state IDLE and out_valid=0; the next full frame completes correctly.
REQ-039 IMG_W=IMG_H=256, random pixels, emboss kernel -> 64516 outputs matching the software model, and done exactly once.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and default geometry for the 3x3 frame controller.
// Holds the FSM state enum and default image/pixel/kernel widths.
package conv_pkg;

  localparam int DEF_IMG_W  = 256;
  localparam int DEF_IMG_H  = 256;
  localparam int DEF_PIX_W  = 8;
  localparam int DEF_KPIX_W = 17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/line_buffer.sv
// Single-clock line RAM, DEPTH x WIDTH, async read / sync write.
// Ports: clk, we, addr, wdata (written on edge), rdata (old contents).
module line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_W,
  parameter int WIDTH = DEF_PIX_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read is combinational, so rdata shows the entry as it was
  // before this cycle's write lands (read-before-write).
  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/conv3x3_frame_ctrl.sv
// Frame sequencer for a 3x3 streaming filter: line buffers, window, FSM.
// Ports: start/busy/done, in_* and out_* valid/ready streams, k_p0..8/k_result.
module conv3x3_frame_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int PIX_W  = DEF_PIX_W,
  parameter int KPIX_W = DEF_KPIX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PIX_W-1:0]  in_pix,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  out_pix,
  output logic [KPIX_W-1:0] k_p0,
  output logic [KPIX_W-1:0] k_p1,
  output logic [KPIX_W-1:0] k_p2,
  output logic [KPIX_W-1:0] k_p3,
  output logic [KPIX_W-1:0] k_p4,
  output logic [KPIX_W-1:0] k_p5,
  output logic [KPIX_W-1:0] k_p6,
  output logic [KPIX_W-1:0] k_p7,
  output logic [KPIX_W-1:0] k_p8,
  input  logic [KPIX_W-1:0] k_result
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_e state_q, state_d;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  logic [PIX_W-1:0] win_q [9];
  logic [PIX_W-1:0] win_d [9];
  logic [PIX_W-1:0] shf   [9];

  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_pix_q, out_pix_d;
  logic             done_q, done_d;

  logic [PIX_W-1:0] lb1_rd;
  logic [PIX_W-1:0] lb2_rd;

  logic accept;
  logic emit;
  logic xfer;
  logic last_pix;
  logic start_ok;
  logic unused_kres;

  assign xfer     = out_valid_q & out_ready;
  assign in_ready = (state_q == ST_RUN) & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign start_ok = (state_q == ST_IDLE) & start;
  assign last_pix = (col_q == COL_LAST) & (row_q == ROW_LAST);

  // Only full windows produce output; the c>=2 gate also keeps a
  // window from ever mixing columns across a row wrap.
  assign emit = accept
              & (row_q >= RW'(2))
              & (col_q >= CW'(2));

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_pix   = out_pix_q;

  assign unused_kres = ^k_result[KPIX_W-1:PIX_W];

  // lb1 holds row r-1, lb2 holds row r-2.
  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W),
    .AW    (CW)
  ) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_q),
    .wdata (in_pix),
    .rdata (lb1_rd)
  );

  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W),
    .AW    (CW)
  ) u_lb2 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_q),
    .wdata (lb1_rd),
    .rdata (lb2_rd)
  );

  // Window after this cycle's shift: old columns move left, the
  // new right column is {r-2, r-1, r} at the current column.
  always_comb begin
    shf[0] = win_q[1];
    shf[1] = win_q[2];
    shf[2] = lb2_rd;
    shf[3] = win_q[4];
    shf[4] = win_q[5];
    shf[5] = lb1_rd;
    shf[6] = win_q[7];
    shf[7] = win_q[8];
    shf[8] = in_pix;
  end

  assign k_p0 = KPIX_W'(shf[0]);
  assign k_p1 = KPIX_W'(shf[1]);
  assign k_p2 = KPIX_W'(shf[2]);
  assign k_p3 = KPIX_W'(shf[3]);
  assign k_p4 = KPIX_W'(shf[4]);
  assign k_p5 = KPIX_W'(shf[5]);
  assign k_p6 = KPIX_W'(shf[6]);
  assign k_p7 = KPIX_W'(shf[7]);
  assign k_p8 = KPIX_W'(shf[8]);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept && last_pix) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The last accept always emits, so out_valid is set here.
        if (xfer) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (start_ok) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d = '0;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      win_d[i] = win_q[i];
    end
    if (accept) begin
      for (int i = 0; i < 9; i++) begin
        win_d[i] = shf[i];
      end
    end
  end

  // An accept is only possible when the held result leaves this
  // cycle, so a new emit can overwrite it without a bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    out_pix_d   = out_pix_q;
    if (xfer) begin
      out_valid_d = 1'b0;
    end
    if (emit) begin
      out_valid_d = 1'b1;
      out_pix_d   = k_result[PIX_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_pix_q   <= out_pix_d;
      done_q      <= done_d;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

endmodule
